sensor_meas_ctrl: RTL and testbench
===================================

SENSOR_MEAS_CTRL -- requirements
Module: sensor_meas_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of sensor channels (2..8).
REQ-002 SHALL have parameter CW, default 24, period-count and timeout width in bits.
REQ-003 SHALL have parameter NPER, default 8, sensor periods measured per channel (1..255).
REQ-004 SHALL have parameter TIMEOUT, default 1000000, per-channel timeout in clk cycles (< 2^CW).
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, one-cycle scan request.
REQ-008 SHALL have port chan_en, input, NCH, per-channel enable mask.
REQ-009 SHALL have port sensor, input, NCH, asynchronous sensor square waves.
REQ-010 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-011 SHALL have port res_valid, output, 1, result available.
REQ-012 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port res_chan, output, 3, channel index of result.
REQ-014 SHALL have port res_cycles, output, CW, clk cycles spanning NPER sensor periods.
REQ-015 SHALL have port res_timeout, output, 1, channel timed out; res_cycles is 0.

Function
REQ-016 SHALL pass each sensor bit through a 2-flop synchronizer, then a rising-edge detector (third flop); edge flag asserts 3 cycles after the input rises.
REQ-017 SHALL implement FSM states IDLE, SELECT, ARM, MEASURE, REPORT.
REQ-018 IDLE: on start=1, latch chan_en into a scan mask, clear channel pointer to 0, go to SELECT; if the latched mask is 0, stay in IDLE with busy=0.
REQ-019 SELECT: if the pointer's mask bit is 1, clear timer, counter and edge count, go to ARM; else advance pointer; past NCH-1 go to IDLE.
REQ-020 ARM: on the first detected rising edge of the selected channel, go to MEASURE with counter=0 and edge count=0.
REQ-021 MEASURE: counter increments each cycle (saturating at 2^CW-1); each detected edge increments the edge count; on the NPER-th edge, capture counter+1 into res_cycles, set res_timeout=0, go to REPORT.
REQ-022 res_cycles SHALL equal the cycle count from the arming edge-detect cycle to the NPER-th edge-detect cycle.
REQ-023 Timer SHALL count every cycle in ARM and MEASURE; on reaching TIMEOUT, set res_cycles=0 and res_timeout=1, and go to REPORT.
REQ-024 If timeout and the NPER-th edge occur in the same cycle, the edge SHALL win (valid measurement).
REQ-025 REPORT: res_valid=1 with res_chan, res_cycles and res_timeout stable; on res_valid&res_ready, advance pointer and go to SELECT next cycle.
REQ-026 Channels SHALL be served in ascending index order, once each per scan; disabled channels are skipped with no result.
REQ-027 busy=1 in every state except IDLE; start while busy SHALL be ignored; chan_en changes mid-scan SHALL be ignored.
REQ-028 Edges on non-selected channels SHALL have no effect.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, busy=0, res_valid=0, res_chan=0, res_cycles=0, res_timeout=0, and clear all synchronizer flops, counters, pointer and mask.
REQ-030 rst asserted mid-scan SHALL abort the scan with no result; after release, no activity occurs until a new start.

Verification (NCH=4, NPER=2, TIMEOUT=1000, res_ready=1 unless noted)
REQ-031 chan_en=0001, sensor[0] period 50 cycles, start -> one result: res_chan=0, res_cycles=100, res_timeout=0; busy falls afterwards.
REQ-032 chan_en=1010, ch1 period 20, ch3 period 37 -> results in order ch1 res_cycles=40, then ch3 res_cycles=74; ch0 and ch2 produce nothing.
REQ-033 chan_en=0100, sensor[2] held low -> res_chan=2, res_timeout=1, res_cycles=0, exactly 1000 cycles after entering ARM.
REQ-034 res_ready=0 for 30 cycles in REPORT -> res_valid and its data held constant, next channel not started; accepted on the first res_ready=1 cycle.
REQ-035 start pulsed again while busy, then rst asserted mid-MEASURE -> second start ignored; outputs zero asynchronously; no result after reset release.
REQ-036 start with chan_en=0000 -> busy stays 0 and res_valid is never asserted.

Source files
------------

// File: rtl/sensor_meas_ctrl.sv
// rtl/sensor_meas_ctrl.sv - multi-channel sensor period measurement controller
// Scans enabled channels in ascending order, timing NPER sensor periods per channel with a timeout.
module sensor_meas_ctrl #(
   parameter int NCH     = 4,
   parameter int CW      = 24,
   parameter int NPER    = 8,
   parameter int TIMEOUT = 1000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [NCH-1:0] chan_en,
   input  logic [NCH-1:0] sensor,
   output logic          busy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [2:0]    res_chan,
   output logic [CW-1:0] res_cycles,
   output logic          res_timeout
);

   typedef enum logic [2:0] {IDLE, SELECT, ARM, MEASURE, REPORT} state_t;

   state_t        state_q, state_d;
   logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
   logic [7:0]    mask_q, mask_d;
   logic [3:0]    ptr_q, ptr_d;
   logic [CW-1:0] timer_q, timer_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    ecnt_q, ecnt_d;
   logic [2:0]    chan_q, chan_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          tmo_q, tmo_d;
   logic [7:0]    edge_ext;
   logic          sel_edge, last_edge, timeout_hit, cnt_sat;

   // Mask and edge vectors are widened to 8 bits so any 3-bit pointer value indexes safely.
   always_comb begin
      edge_ext = '0;
      edge_ext[NCH-1:0] = sync2_q & ~sync3_q;
   end

   assign sel_edge    = edge_ext[ptr_q[2:0]];
   assign last_edge   = sel_edge && (({1'b0, ecnt_q} + 9'd1) == 9'(NPER));
   assign timeout_hit = (timer_q >= CW'(TIMEOUT - 1));
   assign cnt_sat     = &cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         mask_q  <= '0;
         ptr_q   <= '0;
         timer_q <= '0;
         cnt_q   <= '0;
         ecnt_q  <= '0;
         chan_q  <= '0;
         cyc_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sensor;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         ecnt_q  <= ecnt_d;
         chan_q  <= chan_d;
         cyc_q   <= cyc_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      ecnt_d  = ecnt_q;
      chan_d  = chan_q;
      cyc_d   = cyc_q;
      tmo_d   = tmo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mask_d = '0;
               mask_d[NCH-1:0] = chan_en;
               ptr_d = '0;
               if (|chan_en) state_d = SELECT;
            end
         end
         SELECT: begin
            if (ptr_q >= 4'(NCH)) begin
               state_d = IDLE;
            end else if (mask_q[ptr_q[2:0]]) begin
               timer_d = '0;
               cnt_d   = '0;
               ecnt_d  = '0;
               state_d = ARM;
            end else begin
               ptr_d = ptr_q + 4'd1;
            end
         end
         ARM: begin
            timer_d = timer_q + CW'(1);
            if (timeout_hit) begin
               cyc_d   = '0;
               tmo_d   = 1'b1;
               chan_d  = ptr_q[2:0];
               state_d = REPORT;
            end else if (sel_edge) begin
               cnt_d   = '0;
               ecnt_d  = '0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            timer_d = timer_q + CW'(1);
            if (!cnt_sat) cnt_d = cnt_q + CW'(1);
            // A final edge coinciding with the timeout still yields a valid measurement.
            if (last_edge) begin
               cyc_d   = cnt_sat ? cnt_q : cnt_q + CW'(1);
               tmo_d   = 1'b0;
               chan_d  = ptr_q[2:0];
               state_d = REPORT;
            end else begin
               if (sel_edge) ecnt_d = ecnt_q + 8'd1;
               if (timeout_hit) begin
                  cyc_d   = '0;
                  tmo_d   = 1'b1;
                  chan_d  = ptr_q[2:0];
                  state_d = REPORT;
               end
            end
         end
         REPORT: begin
            if (res_ready) begin
               ptr_d   = ptr_q + 4'd1;
               state_d = SELECT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign res_valid   = (state_q == REPORT);
   assign res_chan    = chan_q;
   assign res_cycles  = cyc_q;
   assign res_timeout = tmo_q;

endmodule

// File: tb/tb_sensor_meas_ctrl.sv
// tb/tb_sensor_meas_ctrl.sv - directed self-checking bench for sensor_meas_ctrl
module tb_sensor_meas_ctrl;

   localparam int NCH = 4;
   localparam int CW  = 24;

   logic           clk;
   logic           rst;
   logic           start;
   logic [NCH-1:0] chan_en;
   logic [NCH-1:0] sensor;
   logic           busy;
   logic           res_valid;
   logic           res_ready;
   logic [2:0]     res_chan;
   logic [CW-1:0]  res_cycles;
   logic           res_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int per [NCH];
   int cnt [NCH];

   sensor_meas_ctrl #(.NCH(NCH), .CW(CW), .NPER(2), .TIMEOUT(1000)) dut (
      .clk(clk), .rst(rst), .start(start), .chan_en(chan_en), .sensor(sensor),
      .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
      .res_cycles(res_cycles), .res_timeout(res_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sensor square waves: period per[i] clk cycles, 0 means held low.
   initial begin
      sensor = '0;
      for (int i = 0; i < NCH; i++) begin
         per[i] = 0;
         cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) begin
            if (per[i] == 0) begin
               sensor[i] = 1'b0;
               cnt[i] = 0;
            end else begin
               sensor[i] = (cnt[i] < per[i] / 2);
               cnt[i] = (cnt[i] + 1 >= per[i]) ? 0 : cnt[i] + 1;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [NCH-1:0] en);
      chan_en = en;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int max, output int cyc);
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < max) begin
         tick();
         cyc++;
      end
      check(tag, res_valid, 1);
   endtask

   task automatic quiet_for(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (busy !== 1'b0 || res_valid !== 1'b0) seen = 1'b1;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      int cyc;
      logic held;
      rst = 1'b1;
      start = 1'b0;
      chan_en = '0;
      res_ready = 1'b1;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_chan", res_chan, 0);
      check("rst_cycles", res_cycles, 0);
      check("rst_timeout", res_timeout, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Single channel; a second start mid-scan must not restart or widen the scan.
      per[0] = 50;
      do_start(4'b0001);
      check("t1_busy", busy, 1);
      repeat (3) tick();
      do_start(4'b1111);
      chan_en = 4'b0001;
      wait_valid("t1_valid", 400, cyc);
      check("t1_chan", res_chan, 0);
      check("t1_cycles", res_cycles, 100);
      check("t1_timeout", res_timeout, 0);
      tick();
      repeat (8) tick();
      check("t1_idle", busy, 0);
      quiet_for("t1_quiet", 60);

      // Two sparse channels, served in ascending order; ch0 keeps toggling unselected.
      per[1] = 20;
      per[3] = 37;
      do_start(4'b1010);
      wait_valid("t2_valid_a", 400, cyc);
      check("t2_chan_a", res_chan, 1);
      check("t2_cycles_a", res_cycles, 40);
      check("t2_timeout_a", res_timeout, 0);
      tick();
      wait_valid("t2_valid_b", 400, cyc);
      check("t2_chan_b", res_chan, 3);
      check("t2_cycles_b", res_cycles, 74);
      check("t2_timeout_b", res_timeout, 0);
      tick();
      repeat (8) tick();
      check("t2_idle", busy, 0);

      // Timeout on ch2: 3 SELECT cycles (ch0, ch1 skipped, ch2 armed) then 1000 in ARM.
      do_start(4'b0100);
      wait_valid("t3_valid", 1200, cyc);
      check("t3_latency", cyc, 1003);
      check("t3_chan", res_chan, 2);
      check("t3_timeout", res_timeout, 1);
      check("t3_cycles", res_cycles, 0);
      tick();
      repeat (8) tick();
      check("t3_idle", busy, 0);

      // Backpressure: result held stable while res_ready is low.
      res_ready = 1'b0;
      do_start(4'b0011);
      wait_valid("t4_valid", 400, cyc);
      held = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (res_valid !== 1'b1 || res_chan !== 3'd0 || res_cycles !== 24'd100 || res_timeout !== 1'b0)
            held = 1'b0;
      end
      check("t4_held", held, 1);
      res_ready = 1'b1;
      tick();
      check("t4_accept", res_valid, 0);
      wait_valid("t4_valid_b", 400, cyc);
      check("t4_chan_b", res_chan, 1);
      check("t4_cycles_b", res_cycles, 40);
      tick();
      repeat (8) tick();
      check("t4_idle", busy, 0);

      // Asynchronous reset mid-MEASURE aborts the scan silently.
      do_start(4'b0001);
      repeat (3) tick();
      do_start(4'b1111);
      chan_en = 4'b0001;
      repeat (80) tick();
      check("t5_pre_busy", busy, 1);
      check("t5_pre_valid", res_valid, 0);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_valid", res_valid, 0);
      check("t5_rst_chan", res_chan, 0);
      check("t5_rst_cycles", res_cycles, 0);
      check("t5_rst_timeout", res_timeout, 0);
      repeat (3) tick();
      rst = 1'b0;
      quiet_for("t5_quiet", 300);

      // Empty enable mask never starts a scan.
      do_start(4'b0000);
      check("t6_busy", busy, 0);
      quiet_for("t6_quiet", 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
